// File: rtl/stream_demux_pkg.sv
// Shared types for the stream demultiplexer: FSM state encoding and select-width helper.
package stream_demux_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOCKED = 2'd1,
    ST_DROP   = 2'd2
  } state_e;

  function automatic int sel_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stream_demux_slot.sv
// One-entry registered output slot with valid/ready; payload holds until the handshake completes.
module demux_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_data,
  input  logic         i_last,
  input  logic         i_ready,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  output logic         o_last,
  output logic         o_can_load
);

  logic         r_valid;
  logic [W-1:0] r_data;
  logic         r_last;

  // Load wins over drain so a simultaneous load/drain keeps the slot full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_last  <= i_last;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid    = r_valid;
  assign o_data     = r_data;
  assign o_last     = r_last;
  assign o_can_load = !r_valid || i_ready;

endmodule

// File: rtl/stream_demux.sv
// One-to-many packet router: first-beat select locks the destination until the last beat.
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter int N_OUT = 4,
  parameter int W     = 8,
  localparam int SW   = sel_width(N_OUT)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               up_valid,
  output logic               up_ready,
  input  logic [W-1:0]       up_data,
  input  logic [SW-1:0]      up_sel,
  input  logic               up_last,
  output logic [N_OUT-1:0]   dn_valid,
  input  logic [N_OUT-1:0]   dn_ready,
  output logic [N_OUT*W-1:0] dn_data,
  output logic [N_OUT-1:0]   dn_last,
  output logic               busy,
  output logic               err_sel
);

  state_e             r_state, w_next;
  logic [SW-1:0]      r_lock;
  logic               r_err;
  logic [SW-1:0]      w_dst;
  logic               w_sel_ok, w_dst_ok, w_slot_can, w_accept, w_err_set;
  logic [N_OUT-1:0]   w_load, w_can;

  // Destination decode; up_ready never looks at up_valid.
  always_comb begin
    w_sel_ok   = (32'(up_sel) < 32'(N_OUT));
    w_dst      = (r_state == ST_LOCKED) ? r_lock : up_sel;
    w_dst_ok   = (r_state == ST_LOCKED) || ((r_state == ST_IDLE) && w_sel_ok);
    w_slot_can = 1'b0;
    for (int i = 0; i < N_OUT; i++)
      if (w_dst == SW'(i)) w_slot_can = w_can[i];
    up_ready = w_dst_ok ? w_slot_can : 1'b1;
    w_accept = up_valid && up_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_lock  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_err   <= w_err_set;
      if (w_accept && (r_state == ST_IDLE) && w_sel_ok && !up_last) r_lock <= up_sel;
    end
  end

  always_comb begin
    w_next = r_state;
    if (w_accept) begin
      case (r_state)
        ST_IDLE:   if (!up_last) w_next = w_sel_ok ? ST_LOCKED : ST_DROP;
        ST_LOCKED: if (up_last) w_next = ST_IDLE;
        ST_DROP:   if (up_last) w_next = ST_IDLE;
        default:   w_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_load    = '0;
    w_err_set = w_accept && (r_state == ST_IDLE) && !w_sel_ok;
    busy      = (r_state != ST_IDLE);
    for (int i = 0; i < N_OUT; i++)
      w_load[i] = w_accept && w_dst_ok && (w_dst == SW'(i));
  end

  assign err_sel = r_err;

  for (genvar i = 0; i < N_OUT; i++) begin : gen_slot
    demux_slot #(.W(W)) u_slot (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_load     (w_load[i]),
      .i_data     (up_data),
      .i_last     (up_last),
      .i_ready    (dn_ready[i]),
      .o_valid    (dn_valid[i]),
      .o_data     (dn_data[i*W +: W]),
      .o_last     (dn_last[i]),
      .o_can_load (w_can[i])
    );
  end

endmodule

// File: tb/tb_stream_demux.sv
// Directed plus random bench for stream_demux with N_OUT=3; reference is a per-port pending-beat model.
module tb_stream_demux;
  localparam int N = 3;
  localparam int W = 8;
  localparam int SW = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           up_valid, up_ready, up_last, busy, err_sel;
  logic [W-1:0]   up_data;
  logic [SW-1:0]  up_sel;
  logic [N-1:0]   dn_valid, dn_ready, dn_last;
  logic [N*W-1:0] dn_data;

  stream_demux #(.N_OUT(N), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .up_valid(up_valid), .up_ready(up_ready),
    .up_data(up_data), .up_sel(up_sel), .up_last(up_last),
    .dn_valid(dn_valid), .dn_ready(dn_ready), .dn_data(dn_data),
    .dn_last(dn_last), .busy(busy), .err_sel(err_sel)
  );

  always #5 clk = ~clk;

  // Reference: each port holds at most one undelivered beat {last,data}.
  bit       m_full [N];
  logic [8:0] m_beat [N];
  bit       in_pkt;
  int       pkt_dst;
  bit       m_err;
  int       checks = 0;
  int       errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int cur_dst();
    if (in_pkt) return pkt_dst;
    return (int'(up_sel) < N) ? int'(up_sel) : -1;
  endfunction

  function automatic bit exp_ready();
    int d = cur_dst();
    if (d < 0) return 1'b1;
    return !m_full[d] || dn_ready[d];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_full[i] = 1'b0;
    in_pkt = 1'b0; pkt_dst = -1; m_err = 1'b0;
  endtask

  // Check outputs against the model, then advance the model through the next rising edge.
  task automatic tick(output bit acc);
    int d;
    #1;
    chk("up_ready", up_ready, exp_ready());
    chk("busy", busy, in_pkt);
    chk("err_sel", err_sel, m_err);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("dn_valid%0d", i), dn_valid[i], m_full[i]);
      if (m_full[i]) begin
        chk($sformatf("dn_data%0d", i), dn_data[i*W +: W], m_beat[i][7:0]);
        chk($sformatf("dn_last%0d", i), dn_last[i], m_beat[i][8]);
      end
    end
    acc = up_valid && exp_ready();
    d = cur_dst();
    m_err = 1'b0;
    for (int i = 0; i < N; i++)
      if (m_full[i] && dn_ready[i]) m_full[i] = 1'b0;
    if (acc) begin
      if (!in_pkt && int'(up_sel) >= N) m_err = 1'b1;
      if (d >= 0) begin
        m_full[d] = 1'b1;
        m_beat[d] = {up_last, up_data};
      end
      if (up_last) in_pkt = 1'b0;
      else begin
        if (!in_pkt) pkt_dst = d;
        in_pkt = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int sel, input logic [7:0] data, input bit last);
    bit acc = 1'b0;
    up_valid = 1'b1; up_sel = SW'(sel); up_data = data; up_last = last;
    for (int k = 0; k < 50 && !acc; k++) tick(acc);
    if (!acc) chk("send_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    bit acc;
    up_valid = 1'b0;
    repeat (n) tick(acc);
  endtask

  initial begin
    bit acc;
    rst_n = 1'b0; up_valid = 1'b0; up_sel = '0; up_data = '0; up_last = 1'b0;
    dn_ready = '1;
    model_reset();
    #12;
    chk("rst_dn_valid", dn_valid, 0);
    chk("rst_dn_data", dn_data, 0);
    chk("rst_dn_last", dn_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_sel, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 1: single beat to port 2
    send(2, 8'hA5, 1'b1);
    chk("t1_valid", dn_valid, 3'b100);
    chk("t1_data", dn_data[2*W +: W], 8'hA5);
    chk("t1_last", dn_last, 3'b100);
    idle(2);

    // 2: locked packet ignores later selects
    send(1, 8'h11, 1'b0);
    send(3, 8'h22, 1'b0);
    chk("t2_busy", busy, 1);
    send(3, 8'h33, 1'b1);
    chk("t2_port1", dn_valid, 3'b010);
    chk("t2_idle", busy, 0);
    idle(2);

    // 3: backpressure on port 0 while port 2 drains
    dn_ready = 3'b010;
    send(0, 8'h10, 1'b1);
    send(2, 8'h20, 1'b1);
    up_valid = 1'b1; up_sel = 2'd0; up_data = 8'h30; up_last = 1'b1;
    tick(acc); chk("t3_stall_a", acc, 0);
    dn_ready = 3'b110;
    tick(acc); chk("t3_stall_b", acc, 0);
    chk("t3_port2_drained", dn_valid, 3'b001);
    dn_ready = 3'b111;
    tick(acc); chk("t3_accept", acc, 1);
    idle(2);

    // 4: back-to-back single-beat packets
    for (int k = 0; k < 8; k++) begin
      up_valid = 1'b1; up_sel = SW'(k % 2); up_data = 8'(8'h40 + k); up_last = 1'b1;
      tick(acc); chk("t4_full_rate", acc, 1);
    end
    idle(2);

    // 5: invalid select drops the whole packet
    send(3, 8'hE0, 1'b0);
    chk("t5_err", err_sel, 1);
    send(0, 8'hE1, 1'b0);
    chk("t5_err_once", err_sel, 0);
    send(1, 8'hE2, 1'b1);
    chk("t5_no_valid", dn_valid, 0);
    idle(2);

    // 6: reset mid-packet
    send(1, 8'h41, 1'b0);
    up_valid = 1'b1; up_sel = 2'd2; up_data = 8'h42; up_last = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_dn_valid", dn_valid, 0);
    chk("t6_busy", busy, 0);
    model_reset();
    up_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(0, 8'h55, 1'b1);
    chk("t6_port0", dn_valid, 3'b001);
    idle(2);

    // Random traffic with random downstream stalls
    for (int k = 0; k < 600; k++) begin
      up_valid = ($urandom_range(0, 3) != 0);
      up_sel   = SW'($urandom_range(0, 3));
      up_data  = 8'($urandom);
      up_last  = ($urandom_range(0, 2) == 0);
      dn_ready = N'($urandom);
      tick(acc);
    end
    dn_ready = '1;
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/stream_demux.md
Name: stream_demux

Overview:
One-to-many packet router. It is the distributing end of the mux family: a single upstream valid/ready stream is steered to one of N_OUT downstream valid/ready ports.
- Destination is taken from up_sel on the first beat of a packet and held until the last beat.
- Each output has a one-entry registered slot, so output timing is isolated from the upstream source.
- Sits between a shared source (decoder, arbiter output) and per-consumer pipelines.

Parameters:
N_OUT, 4, number of downstream ports (2..16, need not be a power of two)
W, 8, data width per beat
SW, $clog2(N_OUT) (min 1), width of up_sel; derived, not overridable

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
up_valid  in  1  upstream beat valid
up_ready  out  1  upstream beat accepted when up_valid && up_ready
up_data  in  W  upstream payload
up_sel  in  SW  destination index, sampled on first beat of packet only
up_last  in  1  marks final beat of packet
dn_valid  out  N_OUT  per-port valid
dn_ready  in  N_OUT  per-port ready
dn_data  out  N_OUT*W  per-port payload, port i at [i*W +: W]
dn_last  out  N_OUT  per-port last flag
busy  out  1  1 while a multi-beat packet is locked
err_sel  out  1  one-cycle pulse when a first beat carries up_sel >= N_OUT

Behaviour:
- Reset (async assert, sync deassert handled by system): dn_valid=0, dn_data=0, dn_last=0, state=IDLE, busy=0, err_sel=0, lock register=0, drop flag=0.
- States:
  - IDLE: destination is up_sel.
  - LOCKED: destination is lock register; up_sel ignored.
  - DROP: packet being discarded.
- IDLE transitions on an accepted beat:
  - up_sel < N_OUT, up_last=1: stay IDLE.
  - up_sel < N_OUT, up_last=0: lock register := up_sel, go LOCKED.
  - up_sel >= N_OUT: err_sel=1 next cycle, beat discarded; if up_last=0 go DROP.
- LOCKED: accepted beat with up_last=1 -> IDLE.
- DROP: up_ready=1 unconditionally, beats discarded, no err pulse; accepted up_last=1 -> IDLE.
- Slot rule, port d = current destination:
  - up_ready = !dn_valid[d] || dn_ready[d].
  - up_ready must not depend combinationally on up_valid.
  - Accepted beat loads slot d next cycle: dn_valid[d]=1, dn_data and dn_last captured.
  - Latency: exactly 1 cycle from acceptance to dn_valid.
- Slot drain: dn_valid[i] && dn_ready[i] with no new load clears dn_valid[i]. Load and drain in the same cycle keeps dn_valid[i]=1 with the new data (full throughput, 1 beat/cycle/port).
- Payload hold: dn_data/dn_last of a valid slot are stable until the handshake completes.
- Other ports: slots not targeted drain independently; a stalled port never blocks draining of other ports.
- Ordering: beats of one packet arrive at one port in order; no interleaving of packets on a port.
- busy = (state != IDLE).
- Reset mid-packet: everything clears, partial packet abandoned; the first beat after reset is treated as a new packet.

Decomposition:
- stream_demux_pkg: state enum (IDLE, LOCKED, DROP).
- Sub-module demux_slot (one-entry register with valid/ready, params W), instantiated N_OUT times via generate.
- Top holds the FSM, destination decode, and the up_ready mux.

Test Plan:
1. Single beat: up_sel=2, up_data=8'hA5, up_last=1, all dn_ready=1 -> next cycle dn_valid=4'b0100, port2 data A5, dn_last[2]=1; busy stays 0.
2. Lock: 3-beat packet (11,22,33) with up_sel=1 on beat 1, changed to 3 on beats 2-3 -> all three beats appear on port 1 in order; busy=1 during beats 2-3; IDLE after beat 3.
3. Backpressure: port 0 holding a beat, dn_ready[0]=0, next beat targets 0 -> up_ready=0. Meanwhile port 2 slot drains normally. Raise dn_ready[0] -> beat accepted the same cycle, no loss or duplication.
4. Throughput: 8 back-to-back single-beat packets alternating sel 0/1, dn_ready all 1 -> up_ready constantly 1; each port receives 4 beats, 1-cycle latency.
5. Invalid sel (N_OUT=3): first beat up_sel=3, up_last=0, then 2 more beats -> err_sel pulses once; up_ready=1 throughout; no dn_valid asserted; IDLE after last.
6. Reset mid-packet: assert rst_n=0 during beat 2 of a locked packet -> immediately dn_valid=0, busy=0; after release, a beat with up_sel=0 routes to port 0.
